// File: rtl/hpdmc_sdram_responder_if.sv
// SDR SDRAM command/data bus between an HPDMC-style controller (master) and
// the device-side responder (slave).
interface hpdmc_sdram_responder_if;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [12:0] sdram_adr;
    logic [1:0]  sdram_ba;
    logic [31:0] sdram_dq_in;
    logic [3:0]  sdram_dm;
    logic [31:0] sdram_dq_out;
    logic        sdram_dq_oe;

    modport master (
        output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_adr, sdram_ba, sdram_dq_in, sdram_dm,
        input  sdram_dq_out, sdram_dq_oe
    );

    modport slave (
        input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_adr, sdram_ba, sdram_dq_in, sdram_dm,
        output sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/hpdmc_sdram_responder.sv
// Device-side SDR SDRAM model: decodes commands, tracks banks and timing,
// serves 2-beat bursts from an on-chip array and flags protocol/timing errors.
module hpdmc_sdram_responder #(
    parameter int unsigned sdram_columndepth = 9,
    parameter int unsigned rowdepth          = 13,
    parameter int unsigned mem_aw            = 10,
    parameter int unsigned cas_latency       = 2,
    parameter int unsigned tim_rp            = 2,
    parameter int unsigned tim_rcd           = 2,
    parameter int unsigned tim_rfc           = 8
) (
    input  logic                    sys_clk,
    input  logic                    sdram_rst_n,
    hpdmc_sdram_responder_if.slave  sdram,
    output logic                    err_timing,
    output logic                    err_protocol,
    output logic [3:0]              err_code,
    output logic [15:0]             cmd_count
);

    localparam int unsigned CntW  = 8;
    localparam int unsigned PipeD = cas_latency + 1;
    localparam int unsigned Words = 1 << mem_aw;

    typedef enum logic [2:0] {
        CmdNop, CmdAct, CmdRead, CmdWrite, CmdPre, CmdRef, CmdMrs, CmdBst
    } cmd_e;

    typedef enum logic {BankIdle, BankActive} bank_st_e;

    cmd_e                    cmd;
    logic [1:0]              ba;
    logic [12:0]             adr;

    bank_st_e                bank_st_q [4];
    bank_st_e                bank_st_d [4];
    logic [rowdepth-1:0]     row_q [4];
    logic [rowdepth-1:0]     row_d [4];
    logic [CntW-1:0]         rcd_q [4];
    logic [CntW-1:0]         rcd_d [4];
    logic [CntW-1:0]         pre_q, pre_d, rfc_q, rfc_d;
    logic                    wr_b1_q, wr_b1_d;
    logic [mem_aw-1:0]       wr_b1_idx_q, wr_b1_idx_d;
    logic [PipeD-1:0]        pipe_v_q, pipe_v_d;
    logic [31:0]             pipe_d_q [PipeD];
    logic [31:0]             pipe_d_d [PipeD];
    logic                    err_timing_q, err_protocol_q;
    logic [3:0]              err_code_q;
    logic [15:0]             cmd_count_q;
    logic [31:0]             mem [Words];

    logic                    exec, any_active, timing_class;
    logic [3:0]              cmd_err, err_now;
    logic [sdram_columndepth-1:0] col;
    logic [mem_aw-1:0]       idx0, idx1;

    function automatic logic [CntW-1:0] dec(input logic [CntW-1:0] v);
        return (v == '0) ? '0 : v - CntW'(1);
    endfunction

    assign ba   = sdram.sdram_ba;
    assign adr  = sdram.sdram_adr;
    assign col  = {adr[sdram_columndepth-1:1], 1'b0};
    assign idx0 = mem_aw'({ba, row_q[ba], col});
    assign idx1 = idx0 + mem_aw'(1);

    always_comb begin
        cmd = CmdNop;
        if (!sdram.sdram_cs_n) begin
            unique case ({sdram.sdram_ras_n, sdram.sdram_cas_n, sdram.sdram_we_n})
                3'b011:  cmd = CmdAct;
                3'b101:  cmd = CmdRead;
                3'b100:  cmd = CmdWrite;
                3'b010:  cmd = CmdPre;
                3'b001:  cmd = CmdRef;
                3'b000:  cmd = CmdMrs;
                3'b110:  cmd = CmdBst;
                default: cmd = CmdNop;
            endcase
        end
    end

    always_comb begin
        any_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bank_st_q[i] == BankActive) any_active = 1'b1;
        end
    end

    // Illegal commands still update state so the model keeps tracking the controller;
    // only commands during tRFC are dropped.
    always_comb begin
        bank_st_d = bank_st_q;
        row_d     = row_q;
        for (int i = 0; i < 4; i++) rcd_d[i] = dec(rcd_q[i]);
        pre_d       = dec(pre_q);
        rfc_d       = dec(rfc_q);
        cmd_err     = 4'd0;
        exec        = (cmd != CmdNop) && (rfc_q == '0);
        wr_b1_d     = exec && (cmd == CmdWrite);
        wr_b1_idx_d = idx1;
        if (exec) begin
            unique case (cmd)
                CmdAct: begin
                    if (bank_st_q[ba] == BankActive) cmd_err = 4'd1;
                    else if (pre_q != '0)            cmd_err = 4'd2;
                    bank_st_d[ba] = BankActive;
                    row_d[ba]     = adr[rowdepth-1:0];
                    rcd_d[ba]     = CntW'(tim_rcd);
                end
                CmdRead, CmdWrite: begin
                    if (bank_st_q[ba] != BankActive)          cmd_err = 4'd3;
                    else if (rcd_q[ba] != '0)                 cmd_err = 4'd4;
                    else if (cmd == CmdWrite && |pipe_v_q)    cmd_err = 4'd6;
                end
                CmdPre: begin
                    if (adr[10]) begin
                        for (int i = 0; i < 4; i++) bank_st_d[i] = BankIdle;
                    end else begin
                        bank_st_d[ba] = BankIdle;
                    end
                    pre_d = CntW'(tim_rp);
                end
                CmdRef: begin
                    if (any_active)         cmd_err = 4'd7;
                    else if (pre_q != '0)   cmd_err = 4'd2;
                    rfc_d = CntW'(tim_rfc);
                end
                CmdBst:  cmd_err = 4'd8;
                default: ;
            endcase
        end
        err_now = 4'd0;
        if (cmd != CmdNop) begin
            if (rfc_q != '0)  err_now = 4'd9;
            else if (wr_b1_q) err_now = 4'd5;
            else              err_now = cmd_err;
        end
        timing_class = (err_now == 4'd2) || (err_now == 4'd4) || (err_now == 4'd9);
    end

    // Entry 0 drives the pins; a READ drops beat0/beat1 in at cas_latency-1 and cas_latency.
    always_comb begin
        pipe_v_d = pipe_v_q >> 1;
        for (int i = 0; i < PipeD - 1; i++) pipe_d_d[i] = pipe_d_q[i+1];
        pipe_d_d[PipeD-1] = '0;
        if (exec && cmd == CmdRead) begin
            pipe_v_d[PipeD-2] = 1'b1;
            pipe_v_d[PipeD-1] = 1'b1;
            pipe_d_d[PipeD-2] = mem[idx0];
            pipe_d_d[PipeD-1] = mem[idx1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sdram_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                bank_st_q[i] <= BankIdle;
                row_q[i]     <= '0;
                rcd_q[i]     <= '0;
            end
            for (int i = 0; i < PipeD; i++) pipe_d_q[i] <= '0;
            pre_q          <= '0;
            rfc_q          <= '0;
            wr_b1_q        <= 1'b0;
            wr_b1_idx_q    <= '0;
            pipe_v_q       <= '0;
            err_timing_q   <= 1'b0;
            err_protocol_q <= 1'b0;
            err_code_q     <= 4'd0;
            cmd_count_q    <= 16'd0;
        end else begin
            bank_st_q   <= bank_st_d;
            row_q       <= row_d;
            rcd_q       <= rcd_d;
            pre_q       <= pre_d;
            rfc_q       <= rfc_d;
            wr_b1_q     <= wr_b1_d;
            wr_b1_idx_q <= wr_b1_idx_d;
            pipe_v_q    <= pipe_v_d;
            pipe_d_q    <= pipe_d_d;
            if (err_now != 4'd0) begin
                if (timing_class) err_timing_q   <= 1'b1;
                else              err_protocol_q <= 1'b1;
                if (err_code_q == 4'd0) err_code_q <= err_now;
            end
            if (exec && cmd != CmdBst) cmd_count_q <= cmd_count_q + 16'd1;
        end
    end

    // A new WRITE's beat0 may land in the same cycle as the previous burst's beat1.
    always_ff @(posedge sys_clk) begin
        if (sdram_rst_n) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_b1_q && !sdram.sdram_dm[b])
                    mem[wr_b1_idx_q][8*b +: 8] <= sdram.sdram_dq_in[8*b +: 8];
                if (exec && cmd == CmdWrite && !sdram.sdram_dm[b])
                    mem[idx0][8*b +: 8] <= sdram.sdram_dq_in[8*b +: 8];
            end
        end
    end

    assign sdram.sdram_dq_out = pipe_d_q[0];
    assign sdram.sdram_dq_oe  = pipe_v_q[0];
    assign err_timing         = err_timing_q;
    assign err_protocol       = err_protocol_q;
    assign err_code           = err_code_q;
    assign cmd_count          = cmd_count_q;

endmodule

// File: tb/tb_hpdmc_sdram_responder.sv
// Directed and randomized checks of hpdmc_sdram_responder against a
// word-level memory/schedule model.
module tb_hpdmc_sdram_responder;

    localparam int CL   = 2;
    localparam int COLD = 9;
    localparam int ROWD = 13;
    localparam int MAW  = 10;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    logic        clk;
    logic        rst_n;
    logic        err_timing, err_protocol;
    logic [3:0]  err_code;
    logic [15:0] cmd_count;

    hpdmc_sdram_responder_if bus ();

    hpdmc_sdram_responder dut (
        .sys_clk      (clk),
        .sdram_rst_n  (rst_n),
        .sdram        (bus),
        .err_timing   (err_timing),
        .err_protocol (err_protocol),
        .err_code     (err_code),
        .cmd_count    (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          cnt_m = 0;
    int          oe_cnt, oe_first, oe_last;
    bit          exp_v [int];
    logic [31:0] exp_d [int];
    logic [31:0] mm [int];
    int          open_row [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic int widx(input int b, input int row, input int c);
        int full;
        full = (b << (ROWD + COLD)) | (row << COLD) | (c & ~1);
        return full & ((1 << MAW) - 1);
    endfunction

    function automatic logic [31:0] rdm(input int i);
        return mm.exists(i) ? mm[i] : 32'hx;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (!m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One bus cycle; afterwards the outputs of the following cycle are checked.
    task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                        input logic [31:0] dq, input logic [3:0] dm);
        {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = c;
        bus.sdram_ba    = b;
        bus.sdram_adr   = a;
        bus.sdram_dq_in = dq;
        bus.sdram_dm    = dm;
        if (c != NOP && rst_n) cnt_m++;
        @(posedge clk);
        #1;
        cyc++;
        chk("dq_oe", 32'(bus.sdram_dq_oe), 32'(exp_v.exists(cyc)));
        if (exp_v.exists(cyc)) chk("dq_out", bus.sdram_dq_out, exp_d[cyc]);
        if (bus.sdram_dq_oe === 1'b1) begin
            oe_cnt++;
            if (oe_first < 0) oe_first = cyc;
            oe_last = cyc;
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(NOP, 2'd0, 13'd0, 32'd0, 4'hF);
    endtask

    task automatic rst_step();
        exp_v.delete();
        exp_d.delete();
        rst_n = 1'b0;
        step(NOP, 2'd0, 13'd0, 32'd0, 4'hF);
        rst_n = 1'b1;
        cnt_m = 0;
    endtask

    task automatic cmd_act(input int b, input int row);
        open_row[b] = row;
        step(ACT, 2'(b), 13'(row), 32'd0, 4'hF);
    endtask

    task automatic do_write(input int b, input int c, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [3:0] m0, input logic [3:0] m1);
        int i0, i1;
        i0 = widx(b, open_row[b], c);
        i1 = (i0 + 1) % (1 << MAW);
        step(WR, 2'(b), 13'(c), d0, m0);
        mm[i0] = merge(rdm(i0), d0, m0);
        step(NOP, 2'd0, 13'd0, d1, m1);
        mm[i1] = merge(rdm(i1), d1, m1);
    endtask

    task automatic do_read(input int b, input int c);
        int i0;
        i0 = widx(b, open_row[b], c);
        exp_v[cyc + CL]     = 1'b1;
        exp_d[cyc + CL]     = rdm(i0);
        exp_v[cyc + CL + 1] = 1'b1;
        exp_d[cyc + CL + 1] = rdm((i0 + 1) % (1 << MAW));
        step(RD, 2'(b), 13'(c), 32'd0, 4'hF);
    endtask

    initial begin
        int          b, row, cols [3];
        logic [12:0] padr;
        rst_n = 1'b0;
        oe_first = -1;
        oe_cnt = 0;
        oe_last = 0;
        for (int i = 0; i < 4; i++) open_row[i] = 0;
        rst_step();
        rst_step();
        chk("rst_oe", 32'(bus.sdram_dq_oe), 32'd0);
        chk("rst_dq", bus.sdram_dq_out, 32'd0);
        chk("rst_et", 32'(err_timing), 32'd0);
        chk("rst_ep", 32'(err_protocol), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_cnt", 32'(cmd_count), 32'd0);

        // Basic write then read-back burst.
        cmd_act(1, 'h12);
        nops(2);
        do_write(1, 'h40, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'h0, 4'h0);
        nops(2);
        do_read(1, 'h40);
        step(NOP, 2'd0, 13'd0, 32'd0, 4'hF);
        chk("t1_oe0", 32'(bus.sdram_dq_oe), 32'd1);
        chk("t1_b0", bus.sdram_dq_out, 32'hA5A5A5A5);
        step(NOP, 2'd0, 13'd0, 32'd0, 4'hF);
        chk("t1_oe1", 32'(bus.sdram_dq_oe), 32'd1);
        chk("t1_b1", bus.sdram_dq_out, 32'h5A5A5A5A);
        nops(1);
        chk("t1_et", 32'(err_timing), 32'd0);
        chk("t1_ep", 32'(err_protocol), 32'd0);
        chk("t1_cnt", 32'(cmd_count), 32'd3);

        // Byte mask.
        do_write(1, 'h44, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0, 4'h0);
        do_write(1, 'h44, 32'h12345678, 32'h0, 4'b0011, 4'hF);
        do_read(1, 'h44);
        step(NOP, 2'd0, 13'd0, 32'd0, 4'hF);
        chk("t2_mask", bus.sdram_dq_out, 32'h1234FFFF);
        nops(2);
        chk("t2_code", 32'(err_code), 32'd0);

        // tRCD violation, then a later protocol error must not overwrite the code.
        cmd_act(2, 4);
        nops(1);
        do_read(2, 'h40);
        chk("t3_et", 32'(err_timing), 32'd1);
        chk("t3_ep", 32'(err_protocol), 32'd0);
        chk("t3_code", 32'(err_code), 32'd4);
        cmd_act(2, 4);
        chk("t3_ep2", 32'(err_protocol), 32'd1);
        chk("t3_code2", 32'(err_code), 32'd4);
        nops(3);

        // PRE all, REF, ACT inside tRFC ignored, ACT right at expiry accepted.
        rst_step();
        cmd_act(0, 0);
        cmd_act(3, 1);
        nops(2);
        step(PRE, 2'd0, 13'h400, 32'd0, 4'hF);
        nops(2);
        step(REF, 2'd0, 13'd0, 32'd0, 4'hF);
        chk("t4_ref_ok", 32'(err_code), 32'd0);
        nops(2);
        cmd_act(0, 0);
        chk("t4_code9", 32'(err_code), 32'd9);
        chk("t4_et", 32'(err_timing), 32'd1);
        nops(5);
        cmd_act(0, 0);
        nops(1);
        chk("t4_ep", 32'(err_protocol), 32'd0);
        chk("t4_code", 32'(err_code), 32'd9);
        chk("t4_cnt", 32'(cmd_count), 32'd5);

        // Gapless streaming of three reads, then WRITE while beats are pending.
        rst_step();
        cmd_act(0, 0);
        nops(2);
        for (int k = 0; k < 3; k++) do_write(0, 2 * k, $urandom, $urandom, 4'h0, 4'h0);
        oe_cnt = 0;
        oe_first = -1;
        do_read(0, 0);
        nops(1);
        do_read(0, 2);
        nops(1);
        do_read(0, 4);
        nops(4);
        chk("t5_oe_cnt", 32'(oe_cnt), 32'd6);
        chk("t5_oe_span", 32'(oe_last - oe_first + 1), 32'd6);
        chk("t5_code0", 32'(err_code), 32'd0);
        do_read(0, 0);
        do_write(0, 8, $urandom, $urandom, 4'h0, 4'h0);
        chk("t5_code6", 32'(err_code), 32'd6);
        chk("t5_ep", 32'(err_protocol), 32'd1);
        chk("t5_et", 32'(err_timing), 32'd0);
        nops(3);

        // Reset in the middle of a burst.
        do_read(0, 0);
        nops(1);
        rst_step();
        chk("t6_oe", 32'(bus.sdram_dq_oe), 32'd0);
        chk("t6_dq", bus.sdram_dq_out, 32'd0);
        chk("t6_code", 32'(err_code), 32'd0);
        chk("t6_cnt", 32'(cmd_count), 32'd0);
        do_read(0, 0);
        chk("t6_code3", 32'(err_code), 32'd3);
        nops(4);

        // Randomized legal traffic against the word-level model.
        rst_step();
        for (int it = 0; it < 20; it++) begin
            b   = int'($urandom_range(0, 3));
            row = int'($urandom & 32'h1FFF);
            cmd_act(b, row);
            nops(2);
            for (int k = 0; k < 3; k++) cols[k] = 2 * int'($urandom_range(0, 255));
            for (int k = 0; k < 3; k++) do_write(b, cols[k], $urandom, $urandom, 4'h0, 4'h0);
            for (int k = 0; k < 3; k++)
                do_write(b, cols[k], $urandom, $urandom, 4'($urandom), 4'($urandom));
            for (int k = 0; k < 3; k++) begin
                do_read(b, cols[k]);
                nops(1);
            end
            nops(2);
            padr = ($urandom_range(0, 1) != 0) ? 13'h400 : 13'h000;
            step(PRE, 2'(b), padr, 32'd0, 4'hF);
            nops(2);
        end
        chk("rnd_et", 32'(err_timing), 32'd0);
        chk("rnd_ep", 32'(err_protocol), 32'd0);
        chk("rnd_code", 32'(err_code), 32'd0);
        chk("rnd_cnt", 32'(cmd_count), 32'(cnt_m & 16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpdmc_sdram_responder.md
Name: hpdmc_sdram_responder

Overview:
- Synthesizable SDR SDRAM device-side responder: the receiving end of the HPDMC command bus (cs_n/ras_n/cas_n/we_n/adr/ba).
- Decodes each command cycle, tracks per-bank open rows, enforces tRP/tRCD/tRFC.
- Serves 2-beat 32-bit bursts (one 64-bit controller word) from an on-chip array, with a CAS-latency read pipeline.
- Flags protocol violations through sticky error outputs. Used in FPGA self-test and simulation in place of external SDRAM.

Parameters:
- sdram_columndepth, 9, column address bits.
- rowdepth, 13, row address bits.
- mem_aw, 10, backing array address width in 32-bit words (2^mem_aw words).
- cas_latency, 2, cycles from READ command to first data beat (legal values 2 or 3).
- tim_rp, 2, minimum idle cycles after PRECHARGE before ACTIVATE or AUTO REFRESH.
- tim_rcd, 2, minimum idle cycles after ACTIVATE before READ or WRITE to that bank.
- tim_rfc, 8, cycles after AUTO REFRESH during which only NOP is legal.

Ports:
- sys_clk  in  1  clock.
- sdram_rst_n  in  1  synchronous, active-low reset.
- sdram_cs_n  in  1  chip select.
- sdram_ras_n  in  1  row strobe.
- sdram_cas_n  in  1  column strobe.
- sdram_we_n  in  1  write enable.
- sdram_adr  in  13  address; A10 selects all banks on PRECHARGE.
- sdram_ba  in  2  bank address.
- sdram_dq_in  in  32  write data.
- sdram_dm  in  4  byte write mask, 1 = byte masked.
- sdram_dq_out  out  32  read data.
- sdram_dq_oe  out  1  read data valid / output enable.
- err_timing  out  1  sticky timing violation flag.
- err_protocol  out  1  sticky illegal-command flag.
- err_code  out  4  code of the first error seen.
- cmd_count  out  16  count of non-NOP commands accepted, wraps.

Behaviour:
- Decode {cs_n,ras_n,cas_n,we_n}:
  - 1xxx or 0111 = NOP.
  - 0011 = ACT.
  - 0101 = READ.
  - 0100 = WRITE.
  - 0010 = PRE.
  - 0001 = REF.
  - 0000 = MRS (accepted and ignored; counted).
  - 0110 = BST (protocol error, code 8).
- Per-bank state: IDLE/ACTIVE plus open row register. Global counters: pre_cnt, rcd_cnt[bank], rfc_cnt. Each loads its parameter on the triggering command and decrements to 0.
- ACT:
  - Legal only if the bank is IDLE, pre_cnt==0 and rfc_cnt==0.
  - Bank becomes ACTIVE with row = adr[rowdepth-1:0]; rcd_cnt[ba] = tim_rcd.
  - Bank ACTIVE -> code 1. pre_cnt!=0 -> code 2.
- READ/WRITE:
  - Bank must be ACTIVE (else code 3) and rcd_cnt[ba]==0 (else code 4).
  - Column = adr[sdram_columndepth-1:0] with bit0 forced 0.
- Word index = {ba, row, col} truncated to its low mem_aw bits. Beat1 uses index+1.
- WRITE: beat0 is written from dq_in/dm in the command cycle; beat1 the following cycle. Any non-NOP command in the beat1 cycle -> code 5, and beat1 is still written.
- READ:
  - Data leaves a shift pipeline: dq_oe=1 with beat0 exactly cas_latency cycles after the command, beat1 the next cycle.
  - A READ issued every 2 cycles streams gaplessly.
  - A WRITE while any read beat is still pending -> code 6. The write proceeds; pending read beats are delivered.
- PRE:
  - A10=1 closes all banks; A10=0 closes bank ba.
  - PRE of an idle bank is legal (NOP-like), but still reloads pre_cnt = tim_rp.
- REF:
  - Legal only when all banks are IDLE (else code 7) and pre_cnt==0 (else code 2). Sets rfc_cnt = tim_rfc.
  - Any non-NOP command while rfc_cnt!=0 -> code 9, and the command is ignored.
- Errors:
  - err_timing covers codes 2, 4, 9. err_protocol covers the rest.
  - Flags are sticky. err_code latches only the first error; 0 = none.
- Illegal ACT/READ/WRITE/REF still update state as if legal. This keeps the model tracking the controller after a violation.
- Reset (sdram_rst_n=0 at a sys_clk edge) clears:
  - All banks to IDLE and all counters to 0.
  - The read pipeline is flushed: dq_oe=0, dq_out=0.
  - Error flags and err_code to 0; cmd_count to 0.
  - Array contents are not cleared.
- Reset mid-burst drops the remaining beats.

Test Plan:
- ACT ba=1 row=0x12; 2 NOPs; WRITE col=0x40 dq=0xA5A5A5A5 then 0x5A5A5A5A; 2 NOPs; READ col=0x40 -> dq_oe high on cycles +2,+3 with 0xA5A5A5A5, 0x5A5A5A5A; err flags 0; cmd_count=3.
- WRITE with dm=4'b0011 over a word containing 0xFFFFFFFF, data 0x12345678 -> readback 0x1234FFFF.
- ACT then READ after 1 NOP (tim_rcd=2) -> err_timing=1, err_code=4; a later violation leaves err_code at 4.
- PRE A10=1 with two banks open, REF after 2 NOPs, then ACT during the next 8 cycles -> err_code=9 and the ACT is ignored; ACT after rfc expiry -> bank opens, no new error.
- Back-to-back READs every 2 cycles to cols 0,2,4 -> 6 contiguous dq_oe cycles in order; WRITE issued 1 cycle after a READ -> err_code=6.
- Assert reset during a read burst -> dq_oe=0 the next cycle; all banks IDLE; an immediate READ -> code 3.
